// File: rtl/scan_word_mux.sv
// rtl/scan_word_mux.sv - registered N-to-1 word mux with direct-select and range-scan modes
// One output slot with valid/ready; loads come from a direct request (IDLE) or a scan cursor (SCAN).
module scan_word_mux #(
  parameter int WIDTH = 4,
  parameter int COUNT = 256,
  localparam int SELW = $clog2(COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*COUNT-1:0] in,
  input  logic [SELW-1:0]        sel,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  input  logic                   start,
  input  logic [SELW-1:0]        scan_lo,
  input  logic [SELW-1:0]        scan_hi,
  input  logic                   scan_loop,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   start_err,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_idx,
  output logic                   out_last,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [SELW:0] COUNT_W = (SELW+1)'(COUNT);

  logic [0:0]       state;
  logic [SELW-1:0]  lo, hi, cur;
  logic             loop;
  logic [WIDTH-1:0] words [COUNT];

  logic             free, sel_err, range_ok;
  logic             load_dir, load_scan, load;
  logic [SELW-1:0]  load_idx;
  logic [WIDTH-1:0] load_data;

  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      words[i] = in[i*WIDTH +: WIDTH];
    end
  end

  assign busy = (state == SCAN);

  always_comb begin
    free      = !out_valid || out_ready;
    sel_err   = ({1'b0, sel} >= COUNT_W);
    range_ok  = (scan_lo <= scan_hi) && ({1'b0, scan_hi} < COUNT_W);
    sel_ready = (state == IDLE) && free && !start;
    load_dir  = sel_valid && sel_ready;
    // abort wins over a scan load in the same cycle
    load_scan = (state == SCAN) && !abort && free;
    load      = load_dir || load_scan;
    load_idx  = load_scan ? cur : sel;
    if (load_scan) begin
      load_data = words[cur];
    end else if (sel_err) begin
      load_data = '0;
    end else begin
      load_data = words[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lo        <= '0;
      hi        <= '0;
      cur       <= '0;
      loop      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_err <= 1'b0;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_idx   <= load_idx;
        out_last  <= load_scan && (cur == hi);
        out_err   <= load_dir && sel_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (range_ok) begin
              lo    <= scan_lo;
              hi    <= scan_hi;
              loop  <= scan_loop;
              cur   <= scan_lo;
              state <= SCAN;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
          end else if (load_scan) begin
            if (cur == hi) begin
              if (loop) begin
                cur <= lo;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              cur <= cur + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scan_word_mux.md
Name: scan_word_mux

Overview:
- Parametrised, registered N-to-1 word multiplexer over a packed input vector.
- Word i occupies bits in[i*WIDTH +: WIDTH].
- Adds a valid/ready output stage, a direct-select request port, and an autonomous scan mode that streams a contiguous index range, optionally looping.
- Sits between wide packed status/data buses and narrow serial consumers (UART framers, debug readout).

Parameters:
- WIDTH, 4, bits per word (>=1).
- COUNT, 256, number of words (>=2). SELW = $clog2(COUNT) is a derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in  input  WIDTH*COUNT  packed words; word i = in[i*WIDTH +: WIDTH]
- sel  input  SELW  direct-select index
- sel_valid  input  1  direct request present
- sel_ready  output  1  direct request accepted this cycle when high with sel_valid
- start  input  1  single-cycle scan start pulse
- scan_lo  input  SELW  first scan index
- scan_hi  input  SELW  last scan index
- scan_loop  input  1  1 = wrap hi->lo forever; 0 = single pass
- abort  input  1  stop scan
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse after the last word of a single pass is loaded
- start_err  output  1  one-cycle pulse when start is rejected
- out_data  output  WIDTH  selected word
- out_idx  output  SELW  index of out_data
- out_last  output  1  out_idx == captured scan_hi (scan words only)
- out_err  output  1  direct sel >= COUNT; out_data forced 0
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts

Behaviour:
- **Reset (sync, rst=1 at posedge):**
  - State = IDLE.
  - out_valid, out_data, out_idx, out_last, out_err, busy, done and start_err all 0.
  - Internal lo/hi/loop/cur registers are cleared to 0.
  - Reset mid-scan or mid-stall discards the held word with no handshake.
- **Output slot:**
  - free = !out_valid || out_ready.
  - A load happens only when free; otherwise out_* hold stable while out_valid=1 and out_ready=0.
  - in is sampled combinationally in the load cycle.
  - Latency is 1 cycle from acceptance to out_valid.
  - Full throughput: one word per cycle when out_ready is held high.
- **State IDLE:**
  - sel_ready = free && !start.
  - On sel_valid && sel_ready:
    - out_data = word(sel), out_idx = sel, out_last = 0, out_err = 0, when sel < COUNT.
    - out_data = 0 and out_err = 1 when sel >= COUNT (only possible for non-power-of-2 COUNT).
  - On start: if scan_lo <= scan_hi and scan_hi < COUNT, capture lo/hi/loop, set cur = scan_lo and go to SCAN. Otherwise pulse start_err and stay in IDLE.
  - start has priority over a simultaneous sel_valid; the sel request is not accepted that cycle.
- **State SCAN:**
  - busy = 1 and sel_ready = 0.
  - start is ignored in SCAN: no start_err, no restart.
  - Each cycle free=1, load word(cur) with out_idx = cur, out_last = (cur == hi), out_err = 0.
  - On that load, if cur == hi:
    - loop=1: cur = lo.
    - loop=0: go to IDLE and pulse done in the cycle following the load.
  - Otherwise cur = cur + 1.
  - lo == hi is legal: in single pass it emits exactly one word with out_last=1.
- **abort:**
  - Sampled in SCAN; next state is IDLE, no done pulse.
  - abort has priority over a load in the same cycle: no new word is loaded.
  - A word already in the output slot remains valid until accepted.
  - abort in IDLE has no effect.
- **Scan-range inputs:** scan_lo, scan_hi and scan_loop are only sampled on an accepted start; later changes do not affect a running scan.
- **Arithmetic:** cur is SELW bits. No overflow is possible because hi < COUNT is enforced at start.

Test Plan:
- **Direct select:** WIDTH=4, COUNT=256, word i = i[3:0]^4'h5, out_ready=1. Requests sel=0, 1, 255 back-to-back -> out_data 5, 4, A with out_idx 0, 1, 255, each 1 cycle after acceptance, out_valid continuous.
- **Backpressure:** out_ready=0 for 5 cycles after the sel=7 load -> out_data=2 and out_idx=7 held stable, sel_ready=0, next request not accepted until out_ready=1.
- **Single-pass scan:** lo=10, hi=13, loop=0, out_ready=1 -> idx 10, 11, 12, 13 on consecutive cycles, out_last only on 13, done pulses once, busy falls, sel_ready returns high.
- **Looping scan with abort:** lo=254, hi=255, loop=1 -> idx 254, 255, 254, 255…; abort raised mid-stream -> no further loads, pending word still handshakes, no done pulse.
- **Rejects and collisions:**
  - start with lo=20, hi=5 -> start_err pulse, stays IDLE, no output.
  - start and sel_valid in the same cycle -> scan wins, sel_ready=0.
  - start during SCAN -> ignored.
- **Reset mid-operation:** rst during a scan with out_valid=1 and out_ready=0 -> next cycle all outputs 0 and IDLE; a following direct sel=3 works normally.
